ring_freq_meter: RTL and testbench

- Measures the rising-edge rate of one free-running ring-oscillator tap over a fixed gate window of system clocks.
- Counts edges in a three-digit saturating decimal counter, 000 to 999.
- Emits the hundreds, tens and ones digits in the team's 5-bit grey digit code.
- One instance per ring or ring pair; its digit outputs feed the display digit-select/scan stage directly.

---
 rtl/ring_freq_meter.sv | 196 +++++++++++++++++++
 tb/tb_ring_freq_meter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_freq_meter.sv
// ring_freq_meter: counts rising edges of an asynchronous ring-oscillator tap
// over a gate window of GATE_CYCLES clocks into a saturating 000..999 BCD
// counter and publishes the three digits in the 5-bit grey digit code.
// Optional build macro RING_FREQ_OVF_BLANK_EN: when defined, a saturated
// window shows the decimal-point code on all digits instead of 999.
module ring_freq_meter #(
  parameter int GATE_CYCLES = 20000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ring,
  input  logic       i_en,
  output logic [4:0] o_100,
  output logic [4:0] o_010,
  output logic [4:0] o_001,
  output logic       o_valid,
  output logic       o_ovf
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [4:0] CODE_ZERO  = 5'b10001;
  localparam logic [4:0] CODE_BLANK = 5'b10101;

  typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_p;

  logic [3:0]    d100_q, d100_d, d010_q, d010_d, d001_q, d001_d;
  logic          ovf_q, ovf_d;
  logic [GW-1:0] gate_q, gate_d;

  logic [4:0] out100_q, out100_d, out010_q, out010_d, out001_q, out001_d;
  logic       valid_q, valid_d;
  logic       ovf_out_q, ovf_out_d;

  // BCD digit to grey digit code; non-BCD values cannot occur
  function automatic logic [4:0] grey_enc(input logic [3:0] bcd);
    case (bcd)
      4'd0:    grey_enc = 5'b10001;
      4'd1:    grey_enc = 5'b00001;
      4'd2:    grey_enc = 5'b00011;
      4'd3:    grey_enc = 5'b00010;
      4'd4:    grey_enc = 5'b00110;
      4'd5:    grey_enc = 5'b00100;
      4'd6:    grey_enc = 5'b01100;
      4'd7:    grey_enc = 5'b01000;
      4'd8:    grey_enc = 5'b11000;
      4'd9:    grey_enc = 5'b10000;
      default: grey_enc = 5'b10001;
    endcase
  endfunction

  // Synchronizer chain plus one history flop for rising-edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_ring};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_p = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Next-state logic: gate sequencing, BCD counting and output loading
  always_comb begin
    state_d   = state_q;
    d100_d    = d100_q;
    d010_d    = d010_q;
    d001_d    = d001_q;
    ovf_d     = ovf_q;
    gate_d    = gate_q;
    out100_d  = out100_q;
    out010_d  = out010_q;
    out001_d  = out001_q;
    valid_d   = 1'b0;
    ovf_out_d = ovf_out_q;

    case (state_q)
      IDLE: begin
        d100_d = 4'd0;
        d010_d = 4'd0;
        d001_d = 4'd0;
        ovf_d  = 1'b0;
        gate_d = '0;
        if (i_en) state_d = COUNT;
      end

      COUNT: begin
        if (!i_en) begin
          // Abandon the partial window; published outputs stay as they are
          state_d = IDLE;
          d100_d  = 4'd0;
          d010_d  = 4'd0;
          d001_d  = 4'd0;
          ovf_d   = 1'b0;
          gate_d  = '0;
        end else begin
          if (edge_p) begin
            if (d100_q == 4'd9 && d010_q == 4'd9 && d001_q == 4'd9) begin
              ovf_d = 1'b1;
            end else if (d001_q != 4'd9) begin
              d001_d = d001_q + 4'd1;
            end else begin
              d001_d = 4'd0;
              if (d010_q != 4'd9) begin
                d010_d = d010_q + 4'd1;
              end else begin
                d010_d = 4'd0;
                d100_d = d100_q + 4'd1;
              end
            end
          end
          if (gate_q == GATE_LAST) begin
            state_d = LATCH;
            gate_d  = '0;
          end else begin
            gate_d = gate_q + GW'(1);
          end
        end
      end

      LATCH: begin
        // Publish the finished window; edges arriving now are dropped
`ifdef RING_FREQ_OVF_BLANK_EN
        if (ovf_q) begin
          out100_d = CODE_BLANK;
          out010_d = CODE_BLANK;
          out001_d = CODE_BLANK;
        end else begin
          out100_d = grey_enc(d100_q);
          out010_d = grey_enc(d010_q);
          out001_d = grey_enc(d001_q);
        end
`else
        out100_d = grey_enc(d100_q);
        out010_d = grey_enc(d010_q);
        out001_d = grey_enc(d001_q);
`endif
        ovf_out_d = ovf_q;
        valid_d   = 1'b1;
        d100_d    = 4'd0;
        d010_d    = 4'd0;
        d001_d    = 4'd0;
        ovf_d     = 1'b0;
        gate_d    = '0;
        state_d   = i_en ? COUNT : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      d100_q    <= 4'd0;
      d010_q    <= 4'd0;
      d001_q    <= 4'd0;
      ovf_q     <= 1'b0;
      gate_q    <= '0;
      out100_q  <= CODE_ZERO;
      out010_q  <= CODE_ZERO;
      out001_q  <= CODE_ZERO;
      valid_q   <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d100_q    <= d100_d;
      d010_q    <= d010_d;
      d001_q    <= d001_d;
      ovf_q     <= ovf_d;
      gate_q    <= gate_d;
      out100_q  <= out100_d;
      out010_q  <= out010_d;
      out001_q  <= out001_d;
      valid_q   <= valid_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign o_100   = out100_q;
  assign o_010   = out010_q;
  assign o_001   = out001_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_out_q;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Scoreboard bench for ring_freq_meter. The ring tap is driven on the falling
// clock edge with an exact period of P clocks, so any G-cycle gate window
// holds exactly G/P edges regardless of phase; expected digits are G/P.
module tb_ring_freq_meter;

  localparam int G = 2100;
  localparam logic [4:0] C0 = 5'b10001;
  localparam logic [4:0] C1 = 5'b00001;
  localparam logic [4:0] C2 = 5'b00011;
  localparam logic [4:0] C3 = 5'b00010;
  localparam logic [4:0] C5 = 5'b00100;
  localparam logic [4:0] C7 = 5'b01000;
  localparam logic [4:0] C9 = 5'b10000;
`ifdef RING_FREQ_OVF_BLANK_EN
  localparam logic [4:0] CSAT = 5'b10101;
`else
  localparam logic [4:0] CSAT = C9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ring = 1'b0;
  logic       en = 1'b0;
  logic [4:0] o_100, o_010, o_001;
  logic       o_valid, o_ovf;

  ring_freq_meter #(.GATE_CYCLES(G), .SYNC_STAGES(2)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_ring (ring),
    .i_en   (en),
    .o_100  (o_100),
    .o_010  (o_010),
    .o_001  (o_001),
    .o_valid(o_valid),
    .o_ovf  (o_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [4:0] h;
    logic [4:0] t;
    logic [4:0] o;
    logic       ovf;
    int         cyc;
    int         tag;
  } exp_t;

  exp_t  exp_q[$];
  string names[32];
  int    tag_n = 0;
  int    checks = 0;
  int    failures = 0;
  int    ring_period = 0;
  bit    rst_evt = 1'b0;
  logic [4:0] last_h = C0, last_t = C0, last_o = C0;
  logic       last_ovf = 1'b0;

  // Ring tap generator: one rising edge every ring_period clocks (0 = stuck low)
  initial begin
    int ph = 0;
    int lastp = 0;
    forever begin
      @(negedge clk);
      if (ring_period != lastp) begin
        ph = 0;
        lastp = ring_period;
      end
      if (ring_period == 0) ring = 1'b0;
      else begin
        ring = (ph == 0);
        ph = (ph + 1) % ring_period;
      end
    end
  end

  // Monitor: pops an expectation on each o_valid, checks output stability otherwise
  initial begin
    exp_t e;
    logic [4:0] ph5, pt5, po5;
    logic pov;
    bit have = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid cyc=%0d got %b_%b_%b ovf=%b required no o_valid",
                   cyc, o_100, o_010, o_001, o_ovf);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL %s_latency got cycle %0d required cycle %0d", names[e.tag], cyc, e.cyc);
          end
          checks++;
          if ({o_100, o_010, o_001} !== {e.h, e.t, e.o}) begin
            failures++;
            $display("FAIL %s_digits got %b_%b_%b required %b_%b_%b",
                     names[e.tag], o_100, o_010, o_001, e.h, e.t, e.o);
          end
          checks++;
          if (o_ovf !== e.ovf) begin
            failures++;
            $display("FAIL %s_ovf got %b required %b", names[e.tag], o_ovf, e.ovf);
          end
          $display("TXN %s cyc=%0d digits=%b_%b_%b ovf=%b", names[e.tag], cyc, o_100, o_010, o_001, o_ovf);
        end
      end else if (have && !rst_evt) begin
        checks++;
        if ({o_100, o_010, o_001, o_ovf} !== {ph5, pt5, po5, pov}) begin
          failures++;
          $display("FAIL stable cyc=%0d got %b_%b_%b ovf=%b required %b_%b_%b ovf=%b",
                   cyc, o_100, o_010, o_001, o_ovf, ph5, pt5, po5, pov);
        end
      end
      rst_evt = 1'b0;
      ph5 = o_100;
      pt5 = o_010;
      po5 = o_001;
      pov = o_ovf;
      have = 1'b1;
    end
  end

  task automatic check_reset(input string nm);
    checks++;
    if ({o_100, o_010, o_001} !== {C0, C0, C0} || o_valid !== 1'b0 || o_ovf !== 1'b0) begin
      failures++;
      $display("FAIL %s got %b_%b_%b valid=%b ovf=%b required 10001_10001_10001 valid=0 ovf=0",
               nm, o_100, o_010, o_001, o_valid, o_ovf);
    end
  endtask

  task automatic check_held(input string nm);
    checks++;
    if ({o_100, o_010, o_001, o_ovf} !== {last_h, last_t, last_o, last_ovf}) begin
      failures++;
      $display("FAIL %s got %b_%b_%b ovf=%b required %b_%b_%b ovf=%b",
               nm, o_100, o_010, o_001, o_ovf, last_h, last_t, last_o, last_ovf);
    end
  endtask

  // Measure nwin back-to-back windows at the given ring period
  task automatic run_window(input string nm, input int period, input int nwin,
                            input logic [4:0] h, input logic [4:0] t, input logic [4:0] o,
                            input logic ov);
    exp_t e;
    int m;
    int waited;
    ring_period = period;
    repeat (10) @(negedge clk);
    names[tag_n] = nm;
    en = 1'b1;
    m = cyc;
    for (int k = 0; k < nwin; k++) begin
      e.h = h;
      e.t = t;
      e.o = o;
      e.ovf = ov;
      e.cyc = m + G + 2 + k * (G + 1);
      e.tag = tag_n;
      exp_q.push_back(e);
    end
    tag_n++;
    waited = 0;
    while (exp_q.size() != 0 && waited < nwin * (G + 1) + 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout got %0d windows pending required 0", nm, exp_q.size());
      exp_q.delete();
    end
    en = 1'b0;
    last_h = h;
    last_t = t;
    last_o = o;
    last_ovf = ov;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset("reset_initial");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_window("zero",      0,  1, C0, C0, C0, 1'b0);
    run_window("nominal70", 30, 1, C0, C7, C0, 1'b0);
    run_window("hundred",   21, 1, C1, C0, C0, 1'b0);
    run_window("carry300",  7,  1, C3, C0, C0, 1'b0);
    run_window("mixed525",  4,  1, C5, C2, C5, 1'b0);
    run_window("sat",       2,  1, CSAT, CSAT, CSAT, 1'b1);
    run_window("clear700",  3,  1, C7, C0, C0, 1'b0);

    // Enable abort partway through a window
    ring_period = 7;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (300) @(negedge clk);
    en = 1'b0;
    repeat (30) @(negedge clk);
    check_held("abort_hold");
    run_window("restart300", 7, 1, C3, C0, C0, 1'b0);

    run_window("b2b525", 4, 3, C5, C2, C5, 1'b0);

    // Reset in the middle of a window, with saturated outputs showing
    run_window("sat2", 2, 1, CSAT, CSAT, CSAT, 1'b1);
    ring_period = 21;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (500) @(negedge clk);
    #2 rst_evt = 1'b1;
    rst = 1'b1;
    #1 check_reset("reset_midwindow");
    en = 1'b0;
    #1 rst = 1'b0;
    last_h = C0;
    last_t = C0;
    last_o = C0;
    last_ovf = 1'b0;
    repeat (G + 50) @(negedge clk);
    check_held("reset_no_valid");
    run_window("post_reset100", 21, 1, C1, C0, C0, 1'b0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
